// File: rtl/bram_frame_reader.sv
// -----------------------------------------------------------------------------
// bram_frame_reader
//
// Read-side controller for a dual-port BRAM (port B). It accepts a
// (start address, length) command, issues one read per cycle while output
// credit is available, and streams the returned words out on a valid/ready
// interface. The last beat of the frame is marked, and done pulses once per
// frame.
//
// Timing, counted in rising edges after the command-accept edge:
//   - First m_valid appears RD_LAT+1 edges after accept.
//   - A len=0 frame passes through READ and DRAIN without issuing any read,
//     so done rises 2 edges after accept.
//   - done rises one edge after the handshake of the m_last beat.
//
// Credit scheme: used_cnt counts reads issued but not yet popped from the
// output FIFO. Those reads are either still in the BRAM pipe or already
// sitting in the FIFO. A new read is issued only when
// used_cnt - pop < FIFO_DEPTH, so every returned word always has a FIFO
// slot waiting for it.
//
// Optional feature (macro BRAM_FRAME_READER_SUM_EN):
//   defined   : frame_sum is the modulo-2^DATA_W sum of the beats handshaken
//               in the current frame. It clears on accept and holds after done.
//   undefined : frame_sum is tied to 0.
//
// Ports:
//   rd_clk, rd_rst_n       clock, synchronous active-low reset
//   cmd_valid/cmd_ready    command handshake; cmd_addr start word, cmd_len 0..256
//   bram_rd_en/addr/data   BRAM port B; data valid RD_LAT cycles after enable
//   m_valid/m_ready        output stream handshake; m_data, m_last
//   done                   one-cycle frame-completion pulse
//   frame_sum              frame checksum (0 unless the macro is defined)
// -----------------------------------------------------------------------------
module bram_frame_reader #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              rd_clk,
    input  logic              rd_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W:0]   cmd_len,
    output logic              bram_rd_en,
    output logic [ADDR_W-1:0] bram_rd_addr,
    input  logic [DATA_W-1:0] bram_rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              done,
    output logic [DATA_W-1:0] frame_sum
);

    localparam int LEN_W = ADDR_W + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t             state, state_n;
    logic [ADDR_W-1:0]  next_addr, issue_addr;
    logic [LEN_W-1:0]   len_q, issue_left, emit_cnt;
    logic [CNT_W-1:0]   used_cnt, used_after_pop, fifo_cnt;
    logic [RD_LAT-1:0]  rd_pipe;
    logic [DATA_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic               accept, issue, push, pop, credit_ok;

    // The oldest bit of the valid pipe lines up with the BRAM data it tracks.
    assign push = rd_pipe[RD_LAT-1];

    assign m_valid = (fifo_cnt != '0);
    assign pop     = m_valid && m_ready;
    assign m_data  = fifo_mem[rd_ptr];
    // emit_cnt only changes on a pop, so m_last stays stable while stalled.
    assign m_last  = m_valid && ((emit_cnt + LEN_W'(1)) == len_q);

    // A pop in this cycle frees its credit in time for this cycle's issue.
    assign used_after_pop = used_cnt - CNT_W'(pop);
    assign credit_ok      = used_after_pop < CNT_W'(FIFO_DEPTH);

    // Reset is synchronous, so ready is also held low while reset is asserted.
    assign cmd_ready = (state == IDLE) && rd_rst_n;
    assign done      = (state == DONE);

    // NOTE: every always_comb output gets a default first; any path that
    // leaves a signal unassigned would otherwise infer a latch.
    always_comb begin
        state_n    = state;
        accept     = 1'b0;
        issue      = 1'b0;
        issue_addr = next_addr;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_n = READ;
                    // The first read goes out in the cycle right after accept.
                    if (cmd_len != '0) begin
                        issue      = 1'b1;
                        issue_addr = cmd_addr;
                    end
                end
            end
            READ: begin
                if (issue_left == '0) begin
                    state_n = DRAIN;
                end else if (credit_ok) begin
                    issue = 1'b1;
                end
            end
            DRAIN: begin
                if (emit_cnt == len_q) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            state        <= IDLE;
            bram_rd_en   <= 1'b0;
            bram_rd_addr <= '0;
            next_addr    <= '0;
            len_q        <= '0;
            issue_left   <= '0;
            emit_cnt     <= '0;
            used_cnt     <= '0;
            rd_pipe      <= '0;
        end else begin
            state      <= state_n;
            bram_rd_en <= issue;
            // The address register only moves on an issue, so it holds while idle.
            if (issue) begin
                bram_rd_addr <= issue_addr;
                next_addr    <= issue_addr + ADDR_W'(1);
            end
            used_cnt <= used_after_pop + CNT_W'(issue);
            rd_pipe  <= RD_LAT'({rd_pipe, bram_rd_en});
            if (accept) begin
                len_q      <= cmd_len;
                issue_left <= cmd_len - LEN_W'(issue);
                emit_cnt   <= '0;
            end else begin
                if (issue) issue_left <= issue_left - LEN_W'(1);
                if (pop)   emit_cnt   <= emit_cnt + LEN_W'(1);
            end
        end
    end

    // Output FIFO. Push and pop may occur in the same cycle.
    // NOTE: the storage is reset as well; it is only FIFO_DEPTH words, and
    // the reset makes m_data read as 0 out of reset.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= bram_rd_data;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

`ifdef BRAM_FRAME_READER_SUM_EN
    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n)  sum_q <= '0;
        else if (accept) sum_q <= '0;
        else if (pop)    sum_q <= sum_q + m_data;
    end

    assign frame_sum = sum_q;
`else
    assign frame_sum = '0;
`endif

    // A length above 2^ADDR_W words is not a legal command.
    cmd_len_legal: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
        (cmd_valid && cmd_ready) |-> (!cmd_len[ADDR_W] || (cmd_len[ADDR_W-1:0] == '0)));

    fifo_no_overflow: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
        (push && !pop) |-> (fifo_cnt < CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_bram_frame_reader.sv
module tb_bram_frame_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // DUT 1: RD_LAT = 1
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_addr;
    logic [8:0]  cmd_len;
    logic        bram_rd_en;
    logic [7:0]  bram_rd_addr;
    logic [31:0] bram_rd_data;
    logic        m_valid, m_ready, m_last, done;
    logic [31:0] m_data, frame_sum;

    // DUT 2: RD_LAT = 2
    logic        cmd_valid2, cmd_ready2;
    logic [7:0]  cmd_addr2;
    logic [8:0]  cmd_len2;
    logic        bram_rd_en2;
    logic [7:0]  bram_rd_addr2;
    logic [31:0] bram_rd_data2;
    logic        m_valid2, m_ready2, m_last2, done2;
    logic [31:0] m_data2, frame_sum2;

    bram_frame_reader #(.RD_LAT(1)) u_dut (
        .rd_clk(clk), .rd_rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .bram_rd_en(bram_rd_en), .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .done(done), .frame_sum(frame_sum)
    );

    bram_frame_reader #(.RD_LAT(2)) u_dut2 (
        .rd_clk(clk), .rd_rst_n(rst_n),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_addr(cmd_addr2), .cmd_len(cmd_len2),
        .bram_rd_en(bram_rd_en2), .bram_rd_addr(bram_rd_addr2), .bram_rd_data(bram_rd_data2),
        .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2), .m_last(m_last2),
        .done(done2), .frame_sum(frame_sum2)
    );

    // BRAM model shared by both DUTs: latency 1 for DUT 1, latency 2 for DUT 2.
    logic [31:0] mem [256];
    logic [31:0] q1, q2a, q2b;

    always @(posedge clk) begin
        if (bram_rd_en) q1 <= mem[bram_rd_addr];
        if (bram_rd_en2) q2a <= mem[bram_rd_addr2];
        q2b <= q2a;
    end
    assign bram_rd_data  = q1;
    assign bram_rd_data2 = q2b;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected cycle numbers are counted in negedge samples after the
    // accept edge (sample 0 is the first one after accept).
    typedef struct {
        logic [7:0]  addr;
        logic [8:0]  len;
        logic [31:0] last_word;
        int          first_cyc;
        int          done_cyc;
        logic [7:0]  rd_addr;
    } vec_t;

    vec_t vecs [5];

    // Runs one frame on DUT 1 with m_ready held high and checks every beat.
    task automatic run_frame(input vec_t v, input string tag);
        int          cyc, first, lastc, beats, done_cyc, w;
        logic [31:0] sum, last_data;
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, " ready idle"}, cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        m_ready   = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check({tag, " ready busy"}, cmd_ready, 1'b0);
        first = -1; lastc = -1; beats = 0; done_cyc = -1; cyc = 0;
        sum = '0; last_data = '0;
        while (done_cyc < 0 && cyc < 100) begin
            if (m_valid) begin
                if (first < 0) first = cyc;
                check({tag, " data"}, m_data, mem[(int'(v.addr) + beats) % 256]);
                check({tag, " last"}, m_last, (beats == int'(v.len) - 1));
                sum += m_data;
                last_data = m_data;
                beats++;
                if (m_last) lastc = cyc;
            end
            if (done) begin
                done_cyc = cyc;
`ifdef BRAM_FRAME_READER_SUM_EN
                check({tag, " frame_sum"}, frame_sum, sum);
`else
                check({tag, " frame_sum"}, frame_sum, 32'h0);
`endif
                check({tag, " rd_addr hold"}, bram_rd_addr, v.rd_addr);
                check({tag, " rd_en idle"}, bram_rd_en, 1'b0);
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, " done cycle"}, done_cyc, v.done_cyc);
        check({tag, " done one cycle"}, done, 1'b0);
        check({tag, " ready after"}, cmd_ready, 1'b1);
        check({tag, " beat count"}, beats, int'(v.len));
        check({tag, " first valid"}, first, v.first_cyc);
        if (v.len != 0) begin
            check({tag, " last word"}, last_data, v.last_word);
            check({tag, " no gap"}, lastc - first, int'(v.len) - 1);
        end
    endtask

    initial begin
        int          cyc, hs, idx, issued, popped, max_occ, done2_cyc, w;
        logic        stale_valid, stale_done, stall, hold_l;
        logic [31:0] hold_d, sum2;
        vec_t        v;

        vecs[0] = '{8'h10, 9'd4, 32'hA500_0013, 2, 7, 8'h13};
        vecs[1] = '{8'hFE, 9'd4, 32'hA500_0001, 2, 7, 8'h01};
        vecs[2] = '{8'h00, 9'd1, 32'hA500_0000, 2, 4, 8'h00};
        vecs[3] = '{8'hFF, 9'd2, 32'hA500_0000, 2, 5, 8'h00};
        vecs[4] = '{8'h20, 9'd0, 32'h0,         -1, 2, 8'h00};

        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + i;

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; m_ready = 1'b0;
        cmd_valid2 = 1'b0; cmd_addr2 = '0; cmd_len2 = '0; m_ready2 = 1'b0;
        repeat (3) @(negedge clk);

        check("reset cmd_ready", cmd_ready, 1'b0);
        check("reset rd_en", bram_rd_en, 1'b0);
        check("reset rd_addr", bram_rd_addr, 8'h00);
        check("reset m_valid", m_valid, 1'b0);
        check("reset m_last", m_last, 1'b0);
        check("reset m_data", m_data, 32'h0);
        check("reset done", done, 1'b0);
        check("reset frame_sum", frame_sum, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven frames on DUT 1.
        for (int i = 0; i < 5; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

        // Reset after 3 of 8 beats, then a fresh frame.
        cmd_valid = 1'b1; cmd_addr = 8'h40; cmd_len = 9'd8; m_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        hs = 0; cyc = 0;
        while (hs < 3 && cyc < 50) begin
            if (m_valid) begin
                check("abort data", m_data, mem[8'h40 + hs]);
                hs++;
            end
            @(negedge clk);
            cyc++;
        end
        check("abort beats before reset", hs, 3);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort reset m_valid", m_valid, 1'b0);
        check("abort reset m_data", m_data, 32'h0);
        check("abort reset rd_en", bram_rd_en, 1'b0);
        check("abort reset rd_addr", bram_rd_addr, 8'h00);
        check("abort reset cmd_ready", cmd_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        stale_valid = 1'b0; stale_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            stale_valid |= m_valid;
            stale_done  |= done;
        end
        check("abort stale beat", stale_valid, 1'b0);
        check("abort stale done", stale_done, 1'b0);
        v = '{8'h00, 9'd2, 32'hA500_0001, 2, 5, 8'h01};
        run_frame(v, "post-reset");

        // Full 256-word frame on DUT 2 with m_ready toggling every cycle.
        w = 0;
        while (!cmd_ready2 && w < 20) begin
            @(negedge clk);
            w++;
        end
        cmd_valid2 = 1'b1; cmd_addr2 = 8'h80; cmd_len2 = 9'd256;
        @(negedge clk);
        cmd_valid2 = 1'b0;
        idx = 0; issued = 0; popped = 0; max_occ = 0; done2_cyc = -1; cyc = 0;
        stall = 1'b0; hold_d = '0; hold_l = 1'b0; sum2 = '0;
        while (done2_cyc < 0 && cyc < 2000) begin
            m_ready2 = (cyc % 2 == 0);
            if (bram_rd_en2) issued++;
            if (issued - popped > max_occ) max_occ = issued - popped;
            if (stall) begin
                check("bp valid held", m_valid2, 1'b1);
                check("bp data held", m_data2, hold_d);
                check("bp last held", m_last2, hold_l);
            end
            if (m_valid2 && m_ready2) begin
                check("bp data", m_data2, mem[(8'h80 + idx) % 256]);
                check("bp last", m_last2, (idx == 255));
                sum2 += m_data2;
                idx++;
                popped++;
            end
            stall  = m_valid2 && !m_ready2;
            hold_d = m_data2;
            hold_l = m_last2;
            if (done2) begin
                done2_cyc = cyc;
`ifdef BRAM_FRAME_READER_SUM_EN
                check("bp frame_sum", frame_sum2, sum2);
`else
                check("bp frame_sum", frame_sum2, 32'h0);
`endif
            end
            @(negedge clk);
            cyc++;
        end
        check("bp done seen", (done2_cyc >= 0), 1'b1);
        check("bp beat count", idx, 256);
        check("bp reads issued", issued, 256);
        check("bp occupancy <= 4", (max_occ <= 4), 1'b1);

`ifdef BRAM_FRAME_READER_SUM_EN
        mem[0] = 32'h1; mem[1] = 32'h2; mem[2] = 32'h3; mem[3] = 32'hFFFF_FFFF;
        v = '{8'h00, 9'd4, 32'hFFFF_FFFF, 2, 7, 8'h03};
        run_frame(v, "sum");
        check("sum value held", frame_sum, 32'h0000_0005);
        run_frame(vecs[4], "sum len0");
        check("sum len0 value", frame_sum, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
